frame_serializer: RTL and testbench

FRAME_SERIALIZER -- requirements
Module: frame_serializer

---
 rtl/frame_serializer_if.sv | 21 ++
 rtl/frame_serializer.sv | 130 +++++++++++++
 tb/tb_frame_serializer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_serializer_if.sv
// Beat stream from the frame serializer toward the UART transmitter.
// Valid/ready handshake; a beat moves when both are high at a rising edge.
interface frame_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/frame_serializer.sv
// Snapshots the element array and streams it as one framed burst:
// header, SIZE elements, XOR checksum.
module frame_serializer #(
  parameter int               WIDTH  = 8,
  parameter int               SIZE   = 16,
  parameter logic [WIDTH-1:0] HEADER = WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH*SIZE-1:0] data_in,
  frame_serializer_if.master    tx,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_DATA,
    SEND_CSUM
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic             done_q;
  logic             done_d;
  logic             load;
  logic             fire;
  logic             valid_c;
  logic [WIDTH-1:0] data_c;
  logic [WIDTH-1:0] csum_in;
  logic [WIDTH-1:0] csum_q;
  logic [WIDTH-1:0] snap_q [SIZE];

  // Checksum is folded at capture time so the tail beat is a plain register.
  always_comb begin
    csum_in = '0;
    for (int i = 0; i < SIZE; i++) begin
      csum_in = csum_in ^ data_in[i*WIDTH +: WIDTH];
    end
  end

  assign valid_c = (state_q != IDLE);
  assign fire    = valid_c & tx.tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (fire) begin
          state_d = SEND_DATA;
          idx_d   = '0;
        end
      end
      SEND_DATA: begin
        if (fire) begin
          if (idx_q == LAST) begin
            state_d = SEND_CSUM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      SEND_CSUM: begin
        if (fire) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_c = '0;
    unique case (1'b1)
      (state_q == SEND_HDR):  data_c = HEADER;
      (state_q == SEND_DATA): data_c = snap_q[idx_q];
      (state_q == SEND_CSUM): data_c = csum_q;
      default:                data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      csum_q  <= '0;
      for (int i = 0; i < SIZE; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (load) begin
        csum_q <= csum_in;
        for (int i = 0; i < SIZE; i++) begin
          snap_q[i] <= data_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign tx.tx_valid = valid_c;
  assign tx.tx_data  = data_c;
  assign busy        = valid_c;
  assign done        = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Randomized bench for frame_serializer; expected frames come
// from a queue-based model of header/elements/XOR checksum.
module tb_frame_serializer;
  localparam int W = 8;
  localparam int N = 16;
  localparam int FL = N + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W*N-1:0] data_in;
  logic           busy;
  logic           done;

  frame_serializer_if #(.WIDTH(W)) bus ();

  frame_serializer #(
    .WIDTH  (W),
    .SIZE   (N),
    .HEADER (8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .tx      (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int unstable;
  int busy_low;
  int cycles;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*N-1:0] rand_data();
    logic [W*N-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  // Model: a frame is the header, each element in order, then their XOR.
  function automatic void build_exp(logic [W*N-1:0] d);
    logic [7:0] x;
    x = 8'h00;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(d[i*W +: W]);
      x = x ^ d[i*W +: W];
    end
    exp_q.push_back(x);
  endfunction

  // Launches one frame from IDLE and collects accepted beats into got.
  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  task automatic send_frame(input logic [W*N-1:0] d, input int rmode,
                            input bit flip, input bit poke);
    logic pv;
    logic [7:0] pd;
    logic rdy;
    int k;
    got = {};
    unstable = 0;
    busy_low = 0;
    pv = 1'b0;
    pd = 8'h00;
    k = 0;
    data_in = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (got.size() < FL && k < 400) begin
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      bus.tx_ready = rdy;
      if (poke) start = 1'($urandom);
      if (pv && (bus.tx_valid !== 1'b1 || bus.tx_data !== pd)) unstable++;
      if (bus.tx_valid === 1'b1 && busy !== 1'b1) busy_low++;
      pv = (bus.tx_valid === 1'b1) && !rdy;
      pd = bus.tx_data;
      if (bus.tx_valid === 1'b1 && rdy) got.push_back(bus.tx_data);
      if (flip && got.size() >= 1) data_in = '1;
      k++;
      tick();
    end
    start = 1'b0;
    cycles = k;
  endtask

  task automatic test_reset();
    data_in = rand_data();
    start = 1'b1;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    n_cmp++;
    if (bus.tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", bus.tx_valid);
    end
    n_cmp++;
    if (bus.tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00", bus.tx_data);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
  endtask

  task automatic test_idle();
    bus.tx_ready = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      n_cmp++;
      if ({bus.tx_valid, busy, done} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_c%0d: got v/b/d %b want 000", c,
                 {bus.tx_valid, busy, done});
      end
      tick();
    end
  endtask

  task automatic test_basic();
    logic [W*N-1:0] d;
    d = '0;
    d[5*W +: W] = 8'h3C;
    d[9*W +: W] = 8'hC3;
    build_exp(d);
    send_frame(d, 0, 1'b0, 1'b0);
    n_cmp++;
    if (got.size() !== FL) begin
      n_bad++;
      $display("FAIL basic_len: got %0d want %0d", got.size(), FL);
    end
    for (int i = 0; i < got.size() && i < FL; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got.size() == FL && got[FL-1] !== 8'hFF) begin
      n_bad++;
      $display("FAIL basic_csum: got %h want ff", got[FL-1]);
    end
    n_cmp++;
    if (cycles !== FL) begin
      n_bad++;
      $display("FAIL basic_cycles: got %0d want %0d", cycles, FL);
    end
    n_cmp++;
    if ({done, bus.tx_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_done: got d/v/b %b want 100",
               {done, bus.tx_valid, busy});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_stall();
    logic [W*N-1:0] d;
    d = '0;
    d[5*W +: W] = 8'h3C;
    d[9*W +: W] = 8'hC3;
    build_exp(d);
    send_frame(d, 1, 1'b0, 1'b0);
    n_cmp++;
    if (got.size() !== FL) begin
      n_bad++;
      $display("FAIL stall_len: got %0d want %0d", got.size(), FL);
    end
    for (int i = 0; i < got.size() && i < FL; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stall_beat%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d unstable want 0", unstable);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_snapshot();
    logic [W*N-1:0] d;
    d = rand_data();
    build_exp(d);
    send_frame(d, 2, 1'b1, 1'b1);
    n_cmp++;
    if (got.size() !== FL) begin
      n_bad++;
      $display("FAIL snap_len: got %0d want %0d", got.size(), FL);
    end
    for (int i = 0; i < got.size() && i < FL; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL snap_beat%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (busy_low !== 0 || unstable !== 0) begin
      n_bad++;
      $display("FAIL snap_busy: got %0d/%0d want 0/0", busy_low, unstable);
    end
    tick();
    // Data now all ones; next frame must snapshot it fresh.
    build_exp(data_in);
    send_frame(data_in, 0, 1'b0, 1'b0);
    n_cmp++;
    if (got.size() !== FL || got[FL-1] !== exp_q[FL-1]) begin
      n_bad++;
      $display("FAIL snap_refresh: got len %0d want %0d", got.size(), FL);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W*N-1:0] d;
    for (int f = 0; f < 6; f++) begin
      d = rand_data();
      build_exp(d);
      send_frame(d, 2, 1'b0, 1'b1);
      n_cmp++;
      if (got.size() !== FL) begin
        n_bad++;
        $display("FAIL rand%0d_len: got %0d want %0d", f, got.size(), FL);
      end
      for (int i = 0; i < got.size() && i < FL; i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rand%0d_beat%0d: got %h want %h",
                   f, i, got[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (unstable !== 0 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL rand%0d_hold: got %0d/%b want 0/1",
                 f, unstable, done);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [W*N-1:0] d;
    d = rand_data();
    data_in = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (bus.tx_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mrst_pre: got %b want 1", bus.tx_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.tx_valid, busy, done} !== 3'b000 || bus.tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL mrst_abort: got v/b/d %b data %h want 000 00",
               {bus.tx_valid, busy, done}, bus.tx_data);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({bus.tx_valid, busy, done} !== 3'b000) begin
        n_bad++;
        $display("FAIL mrst_quiet%0d: got %b want 000", c,
                 {bus.tx_valid, busy, done});
      end
    end
    build_exp(d);
    send_frame(d, 0, 1'b0, 1'b0);
    n_cmp++;
    if (got.size() !== FL) begin
      n_bad++;
      $display("FAIL mrst_len: got %0d want %0d", got.size(), FL);
    end
    for (int i = 0; i < got.size() && i < FL; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL mrst_beat%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W*N-1:0] d;
    int pos;
    int k;
    d = rand_data();
    build_exp(d);
    data_in = d;
    bus.tx_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int c = 0; c < 3 * (FL + 1); c++) begin
      pos = c % (FL + 1);
      n_cmp++;
      if (pos < FL) begin
        if ({bus.tx_valid, done} !== 2'b10 || bus.tx_data !== exp_q[pos]) begin
          n_bad++;
          $display("FAIL b2b_c%0d: got v/d %b data %h want 10 %h", c,
                   {bus.tx_valid, done}, bus.tx_data, exp_q[pos]);
        end
      end else begin
        if ({bus.tx_valid, done, busy} !== 3'b010) begin
          n_bad++;
          $display("FAIL b2b_gap%0d: got v/d/b %b want 010", c,
                   {bus.tx_valid, done, busy});
        end
      end
      tick();
    end
    start = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain: got b/d %b%b want 01", busy, done);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    data_in = '0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_idle();
    test_basic();
    test_stall();
    test_snapshot();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
